// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer: one vector instruction becomes VLEN_WORDS single-word
// beats on the 32-bit memory port. Define VSEQ_TIMEOUT_EN to add the handshake watchdog.
module vec_mem_sequencer #(
    parameter int VLEN_WORDS     = 4,
    parameter int VREG_W         = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vld_i,
    input  logic                     vst_i,
    input  logic [31:0]              base_addr_i,
    input  logic [VREG_W-1:0]        vd_idx_i,
    input  logic [32*VLEN_WORDS-1:0] vs_data_i,
    output logic                     mem_req_o,
    output logic                     mem_wr_o,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i,
    output logic                     vrf_wr_en_o,
    output logic [VREG_W-1:0]        vrf_wr_idx_o,
    output logic [32*VLEN_WORDS-1:0] vrf_wr_data_o,
    output logic                     stall_o,
    output logic                     done_o,
    output logic                     err_o
);
    localparam int BEAT_W = (VLEN_WORDS > 1) ? $clog2(VLEN_WORDS) : 1;
    localparam int VEC_W  = 32 * VLEN_WORDS;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(VLEN_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [BEAT_W-1:0]           r_beat;
    logic [BEAT_W-1:0]           w_beat_next;
    logic                        r_is_load;
    logic                        r_err;
    logic [31:0]                 r_base;
    logic [VREG_W-1:0]           r_vd_idx;
    logic [VEC_W-1:0]            r_vs_data;
    logic [VLEN_WORDS-1:0][31:0] r_buf;

    logic        w_start;
    logic        w_misaligned;
    logic        w_latch;
    logic        w_last;
    logic        w_capture;
    logic        w_timeout;
    logic        w_vrf_fire;
    logic [31:0] w_beat_addr;
    logic [31:0] w_vs_elem [VLEN_WORDS];

    assign w_start      = vld_i | vst_i;
    assign w_misaligned = |base_addr_i[1:0];
    assign w_latch      = (r_state == S_IDLE) && w_start;
    assign w_last       = (r_beat == LAST_BEAT);
    assign w_capture    = (r_state == S_WAIT_RSP) && mem_rvalid_i;
    assign w_beat_addr  = r_base + {{(30-BEAT_W){1'b0}}, r_beat, 2'b00};

    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_beat_next  = '0;
                    w_state_next = w_misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    if (r_is_load) begin
                        w_state_next = S_WAIT_RSP;
                    end else if (w_last) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_beat_next = r_beat + BEAT_W'(1);
                    end
                end else if (w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_WAIT_RSP: begin
                if (mem_rvalid_i) begin
                    if (w_last) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_beat_next  = r_beat + BEAT_W'(1);
                        w_state_next = S_REQ;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_is_load <= 1'b0;
            r_err     <= 1'b0;
            r_base    <= '0;
            r_vd_idx  <= '0;
            r_vs_data <= '0;
            r_buf     <= '0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= w_beat_next;
            // Load wins when both issue flags are set
            if (w_latch) begin
                r_is_load <= vld_i;
                r_err     <= w_misaligned;
                r_base    <= base_addr_i;
                r_vd_idx  <= vd_idx_i;
                r_vs_data <= vs_data_i;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_capture) begin
                r_buf[r_beat] <= mem_rdata_i;
            end
        end
    end

`ifdef VSEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] r_wait;
    logic              w_waiting;
    logic              w_progress;

    assign w_waiting  = (r_state == S_REQ) || (r_state == S_WAIT_RSP);
    assign w_progress = ((r_state == S_REQ) && mem_gnt_i) || w_capture;
    assign w_timeout  = w_waiting && !w_progress && (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Every state entry inside the busy phase coincides with a gnt/rvalid, so clearing
    // on progress also covers clearing on entry.
    always_ff @(posedge clk) begin
        if (reset || !w_waiting || w_progress) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
    if (TIMEOUT_CYCLES > 0) begin : g_no_watchdog
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < VLEN_WORDS; gi++) begin : g_elem
            assign w_vs_elem[gi]                 = r_vs_data[gi*32 +: 32];
            assign vrf_wr_data_o[gi*32 +: 32]    = w_vrf_fire ? r_buf[gi] : 32'h0;
        end
    endgenerate

    assign mem_req_o    = (r_state == S_REQ);
    assign mem_wr_o     = mem_req_o && !r_is_load;
    assign mem_addr_o   = mem_req_o ? w_beat_addr : 32'h0;
    assign mem_wdata_o  = mem_wr_o ? w_vs_elem[r_beat] : 32'h0;

    assign done_o       = (r_state == S_DONE);
    assign err_o        = done_o && r_err;
    assign w_vrf_fire   = done_o && r_is_load && !r_err;
    assign vrf_wr_en_o  = w_vrf_fire;
    assign vrf_wr_idx_o = w_vrf_fire ? r_vd_idx : '0;

    // Released in DONE so the pipeline retires the instruction that cycle
    assign stall_o = !reset && (((r_state == S_IDLE) && w_start) ||
                                (r_state == S_REQ) || (r_state == S_WAIT_RSP));

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Scoreboard bench for vec_mem_sequencer: driver queues expected beats/completions,
// a responder models memory, and a monitor compares. Timeout case needs VSEQ_TIMEOUT_EN.
module tb_vec_mem_sequencer;
    localparam int VLEN_WORDS = 4;
    localparam int VREG_W     = 5;
    localparam int VEC_W      = 32 * VLEN_WORDS;
`ifdef VSEQ_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 8;
`else
    localparam int TIMEOUT_CYCLES = 64;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              vld_i, vst_i;
    logic [31:0]       base_addr_i;
    logic [VREG_W-1:0] vd_idx_i;
    logic [VEC_W-1:0]  vs_data_i;
    logic              mem_req_o, mem_wr_o;
    logic [31:0]       mem_addr_o, mem_wdata_o;
    logic              mem_gnt_i, mem_rvalid_i;
    logic [31:0]       mem_rdata_i;
    logic              vrf_wr_en_o;
    logic [VREG_W-1:0] vrf_wr_idx_o;
    logic [VEC_W-1:0]  vrf_wr_data_o;
    logic              stall_o, done_o, err_o;

    vec_mem_sequencer #(
        .VLEN_WORDS(VLEN_WORDS), .VREG_W(VREG_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .vld_i(vld_i), .vst_i(vst_i),
        .base_addr_i(base_addr_i), .vd_idx_i(vd_idx_i), .vs_data_i(vs_data_i),
        .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .vrf_wr_en_o(vrf_wr_en_o), .vrf_wr_idx_o(vrf_wr_idx_o),
        .vrf_wr_data_o(vrf_wr_data_o), .stall_o(stall_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic              err;
        logic              vrf_en;
        logic [VREG_W-1:0] idx;
        logic [VEC_W-1:0]  data;
        int                done_cyc;
    } cpl_t;

    beat_t exp_beats[$];
    cpl_t  exp_cpl[$];
    int    gnt_dly_q[$];
    int    rsp_dly_q[$];

    logic [31:0] mem_init [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_init.exists(a)) return mem_init[a];
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]} ^ 32'h0101_0101;
    endfunction

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          armed    = 1'b0;
    bit          rsp_pend = 1'b0;
    int          gcnt = 0, rcnt = 0, rdly_armed = 0;
    logic [31:0] rsp_addr = 32'h0;

    initial begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            if (rsp_pend) begin
                if (rcnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem_word(rsp_addr);
                    rsp_pend     = 1'b0;
                end else begin
                    rcnt--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_rvalid_i = 1'b1;   // stray response: no read is outstanding
            end
            if (mem_req_o) begin
                if (!armed) begin
                    gcnt       = (gnt_dly_q.size() != 0) ? gnt_dly_q.pop_front() : 0;
                    rdly_armed = (rsp_dly_q.size() != 0) ? rsp_dly_q.pop_front() : 0;
                    armed      = 1'b1;
                end
                if (gcnt == 0) begin
                    mem_gnt_i = 1'b1;
                    armed     = 1'b0;
                    if (!mem_wr_o) begin
                        rsp_pend = 1'b1;
                        rsp_addr = mem_addr_o;
                        rcnt     = rdly_armed;
                    end
                end else begin
                    gcnt--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_gnt_i = 1'b1;      // grant without request
            end
        end
    end

    // ---------------- monitor ----------------
    beat_t mb;
    cpl_t  mc;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (mem_req_o) begin
                    if (exp_beats.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_req: got addr %h, expected no request", mem_addr_o);
                    end else begin
                        mb = exp_beats[0];
                        check("beat_wr", VEC_W'(mem_wr_o), VEC_W'(mb.wr));
                        check("beat_addr", VEC_W'(mem_addr_o), VEC_W'(mb.addr));
                        if (mb.wr) check("beat_wdata", VEC_W'(mem_wdata_o), VEC_W'(mb.wdata));
                        if (mem_gnt_i) void'(exp_beats.pop_front());
                    end
                    check("stall_busy", VEC_W'(stall_o), VEC_W'(1));
                end
                if (done_o) begin
                    if (exp_cpl.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_done: got done_o=1 err_o=%0b, expected none", err_o);
                    end else begin
                        mc = exp_cpl.pop_front();
                        check("done_cycle", VEC_W'(cyc), VEC_W'(mc.done_cyc));
                        check("err", VEC_W'(err_o), VEC_W'(mc.err));
                        check("vrf_en", VEC_W'(vrf_wr_en_o), VEC_W'(mc.vrf_en));
                        if (mc.vrf_en) begin
                            check("vrf_idx", VEC_W'(vrf_wr_idx_o), VEC_W'(mc.idx));
                            check("vrf_data", vrf_wr_data_o, mc.data);
                        end
                        check("stall_done", VEC_W'(stall_o), VEC_W'(0));
                    end
                end else if (vrf_wr_en_o) begin
                    n_checks++; n_fail++;
                    $display("FAIL stray_vrf_write: got vrf_wr_en_o=1, expected 0 outside done");
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_done();
        int budget = 400;
        bit seen   = 1'b0;
        while (!seen && budget > 0) begin
            @(negedge clk);
            if (mem_req_o) begin
                vld_i       = 1'($urandom_range(0, 1));
                vst_i       = 1'($urandom_range(0, 1));
                base_addr_i = $urandom;
                vd_idx_i    = VREG_W'($urandom);
                vs_data_i   = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                vld_i = 1'b0;
                vst_i = 1'b0;
            end
            if (done_o) seen = 1'b1;
            budget--;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got no done_o within 400 cycles, expected completion");
        end
    endtask

    task automatic issue(input bit ld, input bit st, input logic [31:0] base,
                         input logic [VREG_W-1:0] vd, input logic [VEC_W-1:0] vs,
                         input int gd[VLEN_WORDS], input int rd[VLEN_WORDS]);
        cpl_t        c;
        beat_t       b;
        logic [31:0] addr;
        int          lat = 1;
        bit          is_load = ld;
        @(negedge clk);
        vld_i = ld; vst_i = st; base_addr_i = base; vd_idx_i = vd; vs_data_i = vs;
        c.err  = (base[1:0] != 2'b00);
        c.data = '0;
        if (!c.err) begin
            for (int k = 0; k < VLEN_WORDS; k++) begin
                addr    = base + 32'(4 * k);
                b.wr    = !is_load;
                b.addr  = addr;
                b.wdata = vs[32*k +: 32];
                exp_beats.push_back(b);
                gnt_dly_q.push_back(gd[k]);
                rsp_dly_q.push_back(is_load ? rd[k] : 0);
                lat += gd[k] + 1 + (is_load ? rd[k] + 1 : 0);
                if (is_load) c.data[32*k +: 32] = mem_word(addr);
            end
        end
        c.vrf_en   = is_load && !c.err;
        c.idx      = vd;
        c.done_cyc = cyc + lat;
        exp_cpl.push_back(c);
        $display("op %0d: %s base=%h vd=%0d expected_latency=%0d err=%0b",
                 n_checks, is_load ? "load " : "store", base, vd, lat, c.err);
        wait_done();
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, VEC_W'(|{mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, vrf_wr_en_o,
                              vrf_wr_idx_o, vrf_wr_data_o, stall_o, done_o, err_o}), VEC_W'(0));
    endtask

    int          zd[VLEN_WORDS] = '{0, 0, 0, 0};
    int          gd_r[VLEN_WORDS];
    int          rd_r[VLEN_WORDS];
    logic [31:0] rnd;
    logic [31:0] base_r;
    int          sel;
    int          flags;

    initial begin
        reset = 1'b1; vld_i = 1'b0; vst_i = 1'b0; base_addr_i = '0; vd_idx_i = '0; vs_data_i = '0;
        mem_init[32'h1000] = 32'h11; mem_init[32'h1004] = 32'h22;
        mem_init[32'h1008] = 32'h33; mem_init[32'h100C] = 32'h44;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs_zero");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("idle_outputs_zero");

        // zero-wait load: 9 cycles, data {44,33,22,11}
        issue(1'b1, 1'b0, 32'h1000, 5'd3, '0, zd, zd);
        // store with beat 1 grant delayed 2 cycles: 7 cycles
        issue(1'b0, 1'b1, 32'h2000, 5'd9,
              {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, '{0, 2, 0, 0}, zd);
        // wrap-around with both flags: load wins
        issue(1'b1, 1'b1, 32'hFFFF_FFF8, 5'd17, {4{32'h5555_AAAA}}, zd, zd);
        // misaligned: done the cycle after start with err
        issue(1'b1, 1'b0, 32'h1002, 5'd4, '0, zd, zd);

        // reset in WAIT_RSP of beat 2; beat 2 response arrives late, after reset
        @(negedge clk);
        vld_i = 1'b1; vst_i = 1'b0; base_addr_i = 32'h3000; vd_idx_i = 5'd6; vs_data_i = '0;
        for (int k = 0; k < VLEN_WORDS; k++) begin
            exp_beats.push_back('{1'b0, 32'h3000 + 32'(4 * k), 32'h0});
            gnt_dly_q.push_back(0);
            rsp_dly_q.push_back((k == 2) ? 2 : 0);
        end
        $display("op reset-abort: load base=00003000 vd=6");
        repeat (5) begin
            @(negedge clk);
            vld_i = 1'b0;
        end
        @(negedge clk);
        check("abort_in_wait_stall", VEC_W'({stall_o, mem_req_o}), VEC_W'(2'b10));
        reset = 1'b1;
        exp_beats.delete(); exp_cpl.delete(); gnt_dly_q.delete(); rsp_dly_q.delete();
        armed = 1'b0;
        @(negedge clk);
        check_outputs_zero("abort_outputs_zero");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs_zero("late_rvalid_ignored");
        issue(1'b1, 1'b0, 32'h1000, 5'd21, '0, zd, '{1, 0, 2, 0});

`ifdef VSEQ_TIMEOUT_EN
        // grant never arrives: watchdog aborts after TIMEOUT_CYCLES in REQ
        @(negedge clk);
        vld_i = 1'b0; vst_i = 1'b1; base_addr_i = 32'h4000; vs_data_i = {4{32'h1234_5678}};
        exp_beats.push_back('{1'b1, 32'h4000, 32'h1234_5678});
        gnt_dly_q.push_back(100000);
        rsp_dly_q.push_back(0);
        exp_cpl.push_back('{1'b1, 1'b0, '0, '0, cyc + TIMEOUT_CYCLES + 1});
        $display("op timeout: store base=00004000 expected_latency=%0d err=1", TIMEOUT_CYCLES + 1);
        wait_done();
        exp_beats.delete(); gnt_dly_q.delete(); rsp_dly_q.delete();
        armed = 1'b0;
        @(negedge clk);
        check_outputs_zero("timeout_back_to_idle");
`endif

        for (int t = 0; t < 40; t++) begin
            rnd = $urandom;
            sel = $urandom_range(0, 9);
            base_r = rnd;
            if (sel == 0) begin
                if (base_r[1:0] == 2'b00) base_r[0] = 1'b1;
            end else if (sel == 1) begin
                base_r = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
            end else begin
                base_r[1:0] = 2'b00;
            end
            flags = $urandom_range(1, 3);
            for (int k = 0; k < VLEN_WORDS; k++) begin
                gd_r[k] = $urandom_range(0, 3);
                rd_r[k] = $urandom_range(0, 3);
            end
            issue(flags[0], flags[1], base_r, VREG_W'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, gd_r, rd_r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", VEC_W'(exp_cpl.size() + exp_beats.size()), VEC_W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_watchdog: got simulation still running, expected completion");
        $fatal(1, "global watchdog expired");
    end

endmodule
